// File: rtl/zbt_write_serializer.sv
// Buffers host words in a small FIFO and serialises each one into RAM_W-wide
// ZBT write beats on consecutive addresses, LSB beat first, under a grant.
module zbt_write_serializer #(
   parameter int IN_W       = 16,
   parameter int RAM_W      = 8,
   parameter int ADDR_W     = 19,
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_DELAY = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [IN_W-1:0]               in_data,
   input  logic [ADDR_W-1:0]             in_address,
   input  logic                          ram_grant,
   output logic [ADDR_W-1:0]             ram_address,
   output logic                          ram_we_n,
   output logic [RAM_W-1:0]              ram_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy
);

   localparam int BEATS = IN_W / RAM_W;
   localparam int BB    = (BEATS > 1) ? $clog2(BEATS) : 0;
   localparam int BW    = (BB > 0) ? BB : 1;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int LW    = PW + 1;
   localparam int EW    = ADDR_W + IN_W;

   localparam logic [ADDR_W-1:0] BEAT_MASK = ADDR_W'(BEATS - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ISSUE = 1'b1;

   logic [EW-1:0]         mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [EW-1:0]         head;

   logic [0:0]            state;
   logic [0:0]            state_next;
   logic [IN_W-1:0]       shift_reg;
   logic [ADDR_W-1:0]     word_addr;
   logic [BW-1:0]         beat;

   logic [DATA_DELAY-1:0] dl_valid;
   logic [DATA_DELAY-1:0] dl_valid_next;
   logic [RAM_W-1:0]      dl_data [DATA_DELAY];

   logic                  push;
   logic                  pop;
   logic                  issue;
   logic                  last_beat;
   logic                  fifo_empty;
   logic [LW-1:0]         level_next;
   logic [ADDR_W-1:0]     issue_addr;
   logic                  busy_next;

   // No full bypass: a pop in the same cycle does not open the door.
   assign in_ready   = ~rst & (fifo_level != LW'(FIFO_DEPTH));
   assign fifo_empty = (fifo_level == '0);
   assign push       = in_valid & in_ready;
   assign issue      = (state == ISSUE) & ram_grant;
   assign last_beat  = (beat == BW'(BEATS - 1));
   assign pop        = ~fifo_empty & ((state == IDLE) | (issue & last_beat));
   assign head       = mem[rd_ptr];
   assign level_next = fifo_level + LW'(push) - LW'(pop);

   // Base address is beat-aligned; the beat index fills the low bits.
   assign issue_addr    = (word_addr & ~BEAT_MASK) | ADDR_W'(beat);
   assign dl_valid_next = DATA_DELAY'({dl_valid, issue});

   always_comb begin
      state_next = state;
      if (state == IDLE) begin
         if (pop) state_next = ISSUE;
      end else if (issue & last_beat & ~pop) begin
         state_next = IDLE;
      end
   end

   assign busy_next = (level_next != '0) | (state_next == ISSUE) | (|dl_valid_next);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_address, in_data};
   end

   always_ff @(posedge clk) begin
      dl_data[0] <= shift_reg[RAM_W-1:0];
      for (int i = 1; i < DATA_DELAY; i++) dl_data[i] <= dl_data[i-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_level  <= '0;
         state       <= IDLE;
         shift_reg   <= '0;
         word_addr   <= '0;
         beat        <= '0;
         dl_valid    <= '0;
         ram_we_n    <= 1'b1;
         ram_address <= '0;
         ram_data    <= '0;
         busy        <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         fifo_level <= level_next;
         state      <= state_next;
         busy       <= busy_next;
         dl_valid   <= dl_valid_next;
         ram_we_n   <= ~issue;
         if (issue) begin
            ram_address <= issue_addr;
            shift_reg   <= shift_reg >> RAM_W;
            beat        <= beat + 1'b1;
         end
         // A pop on the last granted beat reloads without a bubble.
         if (pop) begin
            {word_addr, shift_reg} <= head;
            beat                   <= '0;
         end
         if (dl_valid[DATA_DELAY-1]) ram_data <= dl_data[DATA_DELAY-1];
      end
   end

endmodule
